// File: rtl/pc_dual_push_fifo.sv
// Program-counter buffer: two push ports per cycle, one first-word-fall-through pop port,
// plus a running count of buffered entries that do not refer to the current character.
module pc_dual_push_fifo #(
    parameter int PC_WIDTH  = 8,
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in0_pc_valid,
    input  logic [PC_WIDTH-1:0]  in0_pc,
    input  logic                 in0_refer_to_char,
    output logic                 in0_pc_ready,
    input  logic                 in1_pc_valid,
    input  logic [PC_WIDTH-1:0]  in1_pc,
    input  logic                 in1_refer_to_char,
    output logic                 in1_pc_ready,
    output logic                 out_pc_valid,
    output logic [PC_WIDTH-1:0]  out_pc,
    output logic                 out_refer_to_char,
    input  logic                 out_pc_ready,
    output logic [CNT_WIDTH-1:0] count,
    output logic [CNT_WIDTH-1:0] cur_char_count,
    output logic                 cur_char_empty
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic                refer_to_char;
    } entry_t;

    entry_t               mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] cur_q, cur_d;
    logic                 push0, push1, pop;
    logic [AW-1:0]        in1_idx;

    // Readies depend on registered occupancy only, so a same-cycle pop never frees a slot.
    assign in0_pc_ready      = (count_q <= CNT_WIDTH'(DEPTH - 1));
    assign in1_pc_ready      = (count_q <= CNT_WIDTH'(DEPTH - 2));
    assign out_pc_valid      = (count_q != '0);
    assign out_pc            = mem_q[rd_ptr_q].pc;
    assign out_refer_to_char = mem_q[rd_ptr_q].refer_to_char;
    assign count             = count_q;
    assign cur_char_count    = cur_q;
    assign cur_char_empty    = (cur_q == '0);

    always_comb begin
        push0    = in0_pc_valid && in0_pc_ready && !flush;
        push1    = in1_pc_valid && in1_pc_ready && !flush;
        pop      = out_pc_valid && out_pc_ready && !flush;
        in1_idx  = push0 ? wr_ptr_q + AW'(1) : wr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        cur_d    = cur_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            cur_d    = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(push0) + AW'(push1);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            count_d  = count_q + CNT_WIDTH'(push0) + CNT_WIDTH'(push1) - CNT_WIDTH'(pop);
            cur_d    = cur_q
                     + CNT_WIDTH'(push0 && !in0_refer_to_char)
                     + CNT_WIDTH'(push1 && !in1_refer_to_char)
                     - CNT_WIDTH'(pop && !out_refer_to_char);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cur_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cur_q    <= cur_d;
        end
    end

    // Storage needs no reset: entries are only observed while counted as valid.
    always_ff @(posedge clk) begin
        if (push0) mem_q[wr_ptr_q] <= '{pc: in0_pc, refer_to_char: in0_refer_to_char};
        if (push1) mem_q[in1_idx]  <= '{pc: in1_pc, refer_to_char: in1_refer_to_char};
    end

endmodule

// File: tb/tb_pc_dual_push_fifo.sv
// Self-checking bench for pc_dual_push_fifo: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_pc_dual_push_fifo;

    localparam int PCW   = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic           clk = 1'b0;
    logic           rst, flush;
    logic           in0_pc_valid, in0_refer_to_char, in0_pc_ready;
    logic [PCW-1:0] in0_pc;
    logic           in1_pc_valid, in1_refer_to_char, in1_pc_ready;
    logic [PCW-1:0] in1_pc;
    logic           out_pc_valid, out_refer_to_char, out_pc_ready;
    logic [PCW-1:0] out_pc;
    logic [CW-1:0]  count, cur_char_count;
    logic           cur_char_empty;

    pc_dual_push_fifo #(.PC_WIDTH(PCW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in0_pc_valid(in0_pc_valid), .in0_pc(in0_pc),
        .in0_refer_to_char(in0_refer_to_char), .in0_pc_ready(in0_pc_ready),
        .in1_pc_valid(in1_pc_valid), .in1_pc(in1_pc),
        .in1_refer_to_char(in1_refer_to_char), .in1_pc_ready(in1_pc_ready),
        .out_pc_valid(out_pc_valid), .out_pc(out_pc),
        .out_refer_to_char(out_refer_to_char), .out_pc_ready(out_pc_ready),
        .count(count), .cur_char_count(cur_char_count), .cur_char_empty(cur_char_empty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PCW-1:0] pc;
        logic           f;
    } ent_t;

    ent_t mq[$];
    int   checks   = 0;
    int   failures = 0;
    bit   acc0, acc1;

    typedef struct {
        int i0v, i0pc, i0f, i1v, i1pc, i1f, ordy, fl;
        int e_valid, e_pc, e_f, e_cnt, e_cur, e_r0, e_r1;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        in0_pc_valid = 0; in0_pc = '0; in0_refer_to_char = 0;
        in1_pc_valid = 0; in1_pc = '0; in1_refer_to_char = 0;
        out_pc_ready = 0; flush = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        mq.delete();
    endtask

    task automatic check_model();
        int nz;
        nz = 0;
        foreach (mq[i]) if (!mq[i].f) nz++;
        chk("count", int'(count), mq.size());
        chk("cur_char_count", int'(cur_char_count), nz);
        chk("cur_char_empty", int'(cur_char_empty), int'(nz == 0));
        chk("out_pc_valid", int'(out_pc_valid), int'(mq.size() != 0));
        chk("in0_pc_ready", int'(in0_pc_ready), int'(mq.size() <= DEPTH - 1));
        chk("in1_pc_ready", int'(in1_pc_ready), int'(mq.size() <= DEPTH - 2));
        if (mq.size() != 0) begin
            chk("out_pc", int'(out_pc), int'(mq[0].pc));
            chk("out_refer_to_char", int'(out_refer_to_char), int'(mq[0].f));
        end
    endtask

    // Check current outputs against the model, then advance one clock and apply the
    // accepted pushes/pop to the model queue.
    task automatic step();
        bit popm;
        check_model();
        acc0 = in0_pc_valid && (mq.size() <= DEPTH - 1) && !flush;
        acc1 = in1_pc_valid && (mq.size() <= DEPTH - 2) && !flush;
        popm = out_pc_ready && (mq.size() != 0) && !flush;
        @(posedge clk); #1;
        if (flush) mq.delete();
        else begin
            if (popm) void'(mq.pop_front());
            if (acc0) mq.push_back('{pc: in0_pc, f: in0_refer_to_char});
            if (acc1) mq.push_back('{pc: in1_pc, f: in1_refer_to_char});
        end
    endtask

    initial begin
        // i0v i0pc i0f i1v i1pc i1f ordy fl | valid pc f cnt cur r0 r1
        vecs[0] = '{1, 'h05, 0, 0, 0,    0, 0, 0,  1, 'h05, 0, 1, 1, 1, 1};
        vecs[1] = '{0, 0,    0, 0, 0,    0, 1, 0,  0, 0,    0, 0, 0, 1, 1};
        vecs[2] = '{1, 'h10, 0, 1, 'h20, 1, 1, 0,  1, 'h10, 0, 2, 1, 1, 1};
        vecs[3] = '{0, 0,    0, 0, 0,    0, 1, 0,  1, 'h20, 1, 1, 0, 1, 1};
        vecs[4] = '{0, 0,    0, 0, 0,    0, 1, 0,  0, 0,    0, 0, 0, 1, 1};
        vecs[5] = '{0, 0,    0, 1, 'h33, 0, 0, 0,  1, 'h33, 0, 1, 1, 1, 1};
        vecs[6] = '{1, 'h41, 1, 1, 'h42, 0, 1, 0,  1, 'h41, 1, 2, 1, 1, 1};
        vecs[7] = '{1, 'h55, 0, 0, 0,    0, 1, 1,  0, 0,    0, 0, 0, 1, 1};

        do_reset();
        chk("reset out_pc_valid", int'(out_pc_valid), 0);
        chk("reset count", int'(count), 0);
        chk("reset cur_char_empty", int'(cur_char_empty), 1);
        chk("reset in1_pc_ready", int'(in1_pc_ready), 1);

        foreach (vecs[i]) begin
            in0_pc_valid = vecs[i].i0v[0]; in0_pc = PCW'(vecs[i].i0pc); in0_refer_to_char = vecs[i].i0f[0];
            in1_pc_valid = vecs[i].i1v[0]; in1_pc = PCW'(vecs[i].i1pc); in1_refer_to_char = vecs[i].i1f[0];
            out_pc_ready = vecs[i].ordy[0]; flush = vecs[i].fl[0];
            @(posedge clk); #1;
            idle_inputs();
            chk($sformatf("vec%0d out_pc_valid", i), int'(out_pc_valid), vecs[i].e_valid);
            if (vecs[i].e_valid != 0) begin
                chk($sformatf("vec%0d out_pc", i), int'(out_pc), vecs[i].e_pc);
                chk($sformatf("vec%0d out_refer_to_char", i), int'(out_refer_to_char), vecs[i].e_f);
            end
            chk($sformatf("vec%0d count", i), int'(count), vecs[i].e_cnt);
            chk($sformatf("vec%0d cur_char_count", i), int'(cur_char_count), vecs[i].e_cur);
            chk($sformatf("vec%0d cur_char_empty", i), int'(cur_char_empty), int'(vecs[i].e_cur == 0));
            chk($sformatf("vec%0d in0_pc_ready", i), int'(in0_pc_ready), vecs[i].e_r0);
            chk($sformatf("vec%0d in1_pc_ready", i), int'(in1_pc_ready), vecs[i].e_r1);
        end

        // Fill to full with single pushes, then pop at full while in0 still offers data.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            in0_pc_valid = 1; in0_pc = PCW'(8'h80 + i); in0_refer_to_char = i[0];
            if (i == DEPTH - 1) begin
                chk("fill15 in0_pc_ready", int'(in0_pc_ready), 1);
                chk("fill15 in1_pc_ready", int'(in1_pc_ready), 0);
            end
            step();
        end
        chk("full in0_pc_ready", int'(in0_pc_ready), 0);
        chk("full in1_pc_ready", int'(in1_pc_ready), 0);
        chk("full out_pc_valid", int'(out_pc_valid), 1);
        in0_pc = 8'hEE; out_pc_ready = 1;
        #1;
        chk("full pop in0_pc_ready", int'(in0_pc_ready), 0);
        step();
        chk("after full pop count", int'(count), DEPTH - 1);
        in0_pc_valid = 0;
        for (int i = 0; i < DEPTH; i++) step();
        check_model();

        // Flush at count 7 with a concurrent push and pop.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            in0_pc_valid = 1; in0_pc = PCW'(i + 1); in0_refer_to_char = 0;
            step();
        end
        chk("preflush count", int'(count), 7);
        in0_pc = 8'hAB; out_pc_ready = 1; flush = 1;
        step();
        flush = 0; in0_pc_valid = 0;
        chk("flush count", int'(count), 0);
        chk("flush out_pc_valid", int'(out_pc_valid), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("postflush out_pc_valid", int'(out_pc_valid), 0);
        end

        // Randomized traffic with producers holding data until accepted.
        do_reset();
        acc0 = 0; acc1 = 0;
        for (int c = 0; c < 600; c++) begin
            if (!in0_pc_valid || acc0) begin
                in0_pc_valid = ($urandom_range(0, 2) != 0);
                in0_pc = PCW'($urandom); in0_refer_to_char = $urandom_range(0, 1) != 0;
            end
            if (!in1_pc_valid || acc1) begin
                in1_pc_valid = ($urandom_range(0, 2) == 0);
                in1_pc = PCW'($urandom); in1_refer_to_char = $urandom_range(0, 1) != 0;
            end
            out_pc_ready = (c % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 79) == 0);
            step();
        end
        idle_inputs();
        check_model();

        // Asynchronous reset between edges with five entries buffered.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in0_pc_valid = 1; in0_pc = PCW'(8'h60 + i); in0_refer_to_char = 0;
            step();
        end
        idle_inputs();
        chk("prereset count", int'(count), 5);
        @(posedge clk); #3;
        rst = 1;
        #1;
        chk("async rst out_pc_valid", int'(out_pc_valid), 0);
        chk("async rst count", int'(count), 0);
        chk("async rst cur_char_empty", int'(cur_char_empty), 1);
        chk("async rst in0_pc_ready", int'(in0_pc_ready), 1);
        @(posedge clk); #1;
        rst = 0;
        mq.delete();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
